// File: rtl/md_iter_unit_if.sv
// Handshake/operand bundle between the control FSM (master) and the
// iterative unsigned multiply/divide unit (slave).
interface md_iter_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/md_iter_unit.sv
// Iterative 32-bit unsigned multiply (shift-add, LSB first) and restoring
// divide (MSB first); 32 iterations, results presented with a done pulse.
module md_iter_unit (
  input  logic       clk,
  input  logic       reset,
  md_iter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic        op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [5:0]  cnt_r;
  logic [63:0] work_r;
  logic        dbz_pend_r;

  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        dbz_r;

  logic        accept_s;
  logic [63:0] work_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_sh_s;
  logic        div_ge_s;
  logic [31:0] div_rem_s;
  logic [4:0]  bit_idx_s;

  // A start only counts when nothing is in flight.
  assign accept_s = bus.start && (state_r != RUN);

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == 6'd31) state_s = DONE;
        else                state_s = RUN;
      end
      DONE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // One multiply or divide iteration on the working register.
  always_comb begin
    work_s    = work_r;
    mul_sum_s = {1'b0, work_r[63:32]};
    div_sh_s  = 33'd0;
    div_ge_s  = 1'b0;
    div_rem_s = 32'd0;
    bit_idx_s = cnt_r[4:0];
    if (op_r == 1'b0) begin
      // Upper half accumulates a; the 33rd bit keeps the carry before the shift.
      if (b_r[bit_idx_s]) mul_sum_s = {1'b0, work_r[63:32]} + {1'b0, a_r};
      else                mul_sum_s = {1'b0, work_r[63:32]};
      work_s = {mul_sum_s, work_r[31:1]};
    end else begin
      // work_r[63:32] is the partial remainder, work_r[31:0] collects quotient bits.
      bit_idx_s = 5'd31 - cnt_r[4:0];
      div_sh_s  = {work_r[63:32], a_r[bit_idx_s]};
      div_ge_s  = (div_sh_s >= {1'b0, b_r});
      if (div_ge_s) div_rem_s = div_sh_s[31:0] - b_r;
      else          div_rem_s = div_sh_s[31:0];
      work_s = {div_rem_s, work_r[30:0], div_ge_s};
    end
  end

  // State, operand latches, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      op_r       <= 1'b0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      cnt_r      <= 6'd0;
      work_r     <= 64'd0;
      dbz_pend_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      dbz_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      if (accept_s) begin
        op_r       <= bus.op;
        a_r        <= bus.a;
        b_r        <= bus.b;
        cnt_r      <= 6'd0;
        work_r     <= 64'd0;
        dbz_pend_r <= bus.op && (bus.b == 32'd0);
        hi_r       <= 32'd0;
        lo_r       <= 32'd0;
        dbz_r      <= 1'b0;
      end else if (state_r == RUN) begin
        work_r <= work_s;
        cnt_r  <= cnt_r + 6'd1;
        if (state_s == DONE) begin
          hi_r  <= work_s[63:32];
          lo_r  <= work_s[31:0];
          dbz_r <= dbz_pend_r;
        end else begin
          hi_r  <= hi_r;
          lo_r  <= lo_r;
          dbz_r <= dbz_r;
        end
      end else begin
        work_r <= work_r;
        cnt_r  <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed scoreboard bench for md_iter_unit: stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_md_iter_unit;

  logic clk;
  logic reset;

  md_iter_if itf ();

  md_iter_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (itf.slave)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (itf.busy && itf.done) begin
        checks++;
        errors++;
        $display("FAIL busy_and_done: got busy=1 done=1 want not both");
      end
      if (itf.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 want no pending op");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("hi", itf.hi, e.hi);
          check("lo", itf.lo, e.lo);
          check("div_by_zero", {31'd0, itf.div_by_zero}, {31'd0, e.dbz});
        end
      end
    end
  end

  // Drive a start for one edge (caller is just past a negedge), then scramble operands.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input bit push);
    itf.start = 1'b1;
    itf.op    = op;
    itf.a     = a;
    itf.b     = b;
    if (push) exp_q.push_back('{hi: ehi, lo: elo, dbz: edbz});
    @(posedge clk);
    #1;
    itf.start = 1'b0;
    itf.op    = ~op;
    itf.a     = $urandom;
    itf.b     = $urandom;
  endtask

  // Count cycles to done; optionally inject an ignored start or a reset.
  task automatic wait_op(input string name, input int inject_at, input int abort_at);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      n++;
      if (itf.busy) busy_cnt++;
      if (n == inject_at) begin
        itf.start = 1'b1;
        itf.op    = 1'b1;
        itf.a     = 32'd50;
        itf.b     = 32'd3;
      end else if (n == inject_at + 1) begin
        itf.start = 1'b0;
      end
      if (n == abort_at) begin
        reset = 1'b1;
        #1;
        check({name, "_rst_busy"}, {31'd0, itf.busy}, 32'd0);
        check({name, "_rst_done"}, {31'd0, itf.done}, 32'd0);
        check({name, "_rst_hi"}, itf.hi, 32'd0);
        check({name, "_rst_lo"}, itf.lo, 32'd0);
        check({name, "_rst_dbz"}, {31'd0, itf.div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        check({name, "_rst_hold_done"}, {31'd0, itf.done}, 32'd0);
        reset = 1'b0;
        return;
      end
      if (itf.done || n >= 100) break;
    end
    check({name, "_latency"}, n, 32'd33);
    check({name, "_busy_cycles"}, busy_cnt, 32'd32);
  endtask

  initial begin
    reset     = 1'b1;
    itf.start = 1'b0;
    itf.op    = 1'b0;
    itf.a     = 32'd0;
    itf.b     = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, itf.busy}, 32'd0);
    check("reset_done", {31'd0, itf.done}, 32'd0);
    check("reset_hi", itf.hi, 32'd0);
    check("reset_lo", itf.lo, 32'd0);
    check("reset_dbz", {31'd0, itf.div_by_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 32'hFFFE0001, 1'b0, 1'b1);
    wait_op("mul_ffff", 0, 0);
    @(negedge clk);
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
    wait_op("mul_max", 0, 0);
    @(negedge clk);
    issue(1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0, 1'b1);
    wait_op("mul_carry", 0, 0);
    @(negedge clk);
    issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    wait_op("div_100_7", 0, 0);
    @(negedge clk);
    issue(1'b1, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b1);
    wait_op("div_big", 0, 0);
    @(negedge clk);
    issue(1'b1, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1);
    wait_op("div_zero", 0, 0);
    @(negedge clk);
    check("dbz_held_after_done", {31'd0, itf.div_by_zero}, 32'd1);

    // Start while busy is ignored; a start in the done cycle is accepted.
    issue(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
    wait_op("mul_3x5_ignore", 10, 0);
    issue(1'b1, 32'd45, 32'd6, 32'd3, 32'd7, 1'b0, 1'b1);
    wait_op("b2b_div", 0, 0);
    @(negedge clk);

    issue(1'b1, 32'hDEADBEEF, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_op("div_abort", 0, 12);
    @(negedge clk);
    issue(1'b0, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0, 1'b1);
    wait_op("mul_after_rst", 0, 0);
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
